// File: rtl/mcp3201_emulator.sv
// MCP3201-style SPI responder: latches adc_value at CS fall and shifts it out
// MSB-first then LSB-first, with pins synchronized into the clk domain.
module mcp3201_emulator #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      adc_value,
    input  logic             cs_pin_n,
    input  logic             clk_pin,
    output logic             miso_pin,
    output logic             miso_oe,
    output logic             busy,
    output logic             frame_done,
    output logic             short_frame,
    output logic [CNT_W-1:0] frame_count
);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        MSB,
        LSB,
        ZERO
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic                   cs_prev;
    logic                   sck_prev;
    logic [2:0]             fill_cnt;

    logic cs_s;
    logic sck_s;
    logic cs_fall;
    logic cs_rise;
    logic sck_fall;
    logic fill_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b0;
            fill_cnt <= 3'd0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], cs_pin_n};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], clk_pin};
            cs_prev  <= cs_s;
            sck_prev <= sck_s;
            if (!fill_ok)
                fill_cnt <= fill_cnt + 3'd1;
        end
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_prev & ~cs_s;
    assign cs_rise  = ~cs_prev & cs_s;
    assign sck_fall = sck_prev & ~sck_s;
    // The reset value of the cs chain is not a real pin level; arm only once it has flushed.
    assign fill_ok  = (fill_cnt == 3'(SYNC_STAGES));

    state_t             state_q, state_d;
    logic [4:0]         n_q, n_d;
    logic [11:0]        shadow_q, shadow_d;
    logic               armed_q, armed_d;
    logic               miso_q, miso_d;
    logic               oe_q, oe_d;
    logic               done_q, done_d;
    logic               short_q, short_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [4:0] n_inc;
    logic [4:0] msb_idx;
    logic [4:0] lsb_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            n_q      <= 5'd0;
            shadow_q <= 12'd0;
            armed_q  <= 1'b0;
            miso_q   <= 1'b0;
            oe_q     <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            shadow_q <= shadow_d;
            armed_q  <= armed_d;
            miso_q   <= miso_d;
            oe_q     <= oe_d;
            done_q   <= done_d;
            short_q  <= short_d;
            cnt_q    <= cnt_d;
        end
    end

    assign n_inc   = (n_q == 5'd31) ? n_q : n_q + 5'd1;
    assign msb_idx = 5'd14 - n_inc;
    assign lsb_idx = n_inc - 5'd14;

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        shadow_d = shadow_q;
        armed_d  = armed_q;
        miso_d   = miso_q;
        oe_d     = oe_q;
        done_d   = 1'b0;
        short_d  = 1'b0;
        cnt_d    = cnt_q;

        if (state_q == IDLE) begin
            oe_d = 1'b0;
            if (cs_s && fill_ok)
                armed_d = 1'b1;
            if (cs_fall && armed_q) begin
                shadow_d = adc_value;
                n_d      = 5'd0;
                miso_d   = 1'b0;
                oe_d     = 1'b1;
                armed_d  = 1'b0;
                state_d  = SAMPLE;
            end
        end else if (cs_rise) begin
            // CS rise takes priority over a coincident clock fall.
            state_d = IDLE;
            oe_d    = 1'b0;
            miso_d  = 1'b0;
            if (n_q >= 5'd15) begin
                done_d = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
            end else begin
                short_d = 1'b1;
            end
        end else if (sck_fall) begin
            n_d = n_inc;
            unique case (state_q)
                SAMPLE: begin
                    if (n_inc == 5'd2) begin
                        miso_d  = 1'b0;
                        state_d = MSB;
                    end
                end
                MSB: begin
                    miso_d = shadow_q[msb_idx[3:0]];
                    if (n_inc == 5'd14)
                        state_d = LSB;
                end
                LSB: begin
                    miso_d = shadow_q[lsb_idx[3:0]];
                    if (n_inc == 5'd25)
                        state_d = ZERO;
                end
                ZERO: begin
                    miso_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign miso_pin    = miso_q;
    assign miso_oe     = oe_q;
    assign busy        = (state_q != IDLE);
    assign frame_done  = done_q;
    assign short_frame = short_q;
    assign frame_count = cnt_q;

endmodule

// File: tb/tb_mcp3201_emulator.sv
// Directed bench for mcp3201_emulator: an SPI initiator drives frames and
// each sampled bit is checked against the MCP3201 frame-order model.
module tb_mcp3201_emulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] adc_value = 12'd0;
    logic        cs_pin_n = 1'b1;
    logic        clk_pin = 1'b0;

    logic        miso_pin, miso_oe, busy, frame_done, short_frame;
    logic [15:0] frame_count;
    logic        miso_pin2, miso_oe2, busy2, frame_done2, short_frame2;
    logic [1:0]  frame_count2;

    mcp3201_emulator #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .adc_value(adc_value),
        .cs_pin_n(cs_pin_n), .clk_pin(clk_pin),
        .miso_pin(miso_pin), .miso_oe(miso_oe), .busy(busy),
        .frame_done(frame_done), .short_frame(short_frame),
        .frame_count(frame_count)
    );

    // Narrow counter instance exercises frame_count wrap-around.
    mcp3201_emulator #(.SYNC_STAGES(2), .CNT_W(2)) dut_w (
        .clk(clk), .rst(rst), .adc_value(adc_value),
        .cs_pin_n(cs_pin_n), .clk_pin(clk_pin),
        .miso_pin(miso_pin2), .miso_oe(miso_oe2), .busy(busy2),
        .frame_done(frame_done2), .short_frame(short_frame2),
        .frame_count(frame_count2)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int short_cnt = 0;
    int model_frames = 0;

    always @(posedge clk) begin
        if (frame_done) done_cnt = done_cnt + 1;
        if (short_frame) short_cnt = short_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit seen at rising SPI edge k (1-based) in an MCP3201 frame.
    function automatic logic exp_bit(input int k, input logic [11:0] v);
        if (k >= 4 && k <= 15) return v[15-k];
        if (k >= 16 && k <= 26) return v[k-15];
        return 1'b0;
    endfunction

    task automatic frame(input logic [11:0] val, input int nclk,
                         input int half, input int chg_edge,
                         input logic [11:0] chg_val, input int rst_edge,
                         output logic [31:0] bits);
        int  d0;
        int  s0;
        bit  aborted;
        d0 = done_cnt;
        s0 = short_cnt;
        aborted = 1'b0;
        bits = 32'd0;
        adc_value = val;
        @(negedge clk);
        cs_pin_n = 1'b0;
        for (int k = 1; k <= nclk; k++) begin
            repeat (half) @(negedge clk);
            clk_pin = 1'b1;
            if (!aborted) begin
                check($sformatf("bit%0d", k), 32'(miso_pin),
                      32'(exp_bit(k, val)));
                check("oe_in_frame", 32'(miso_oe), 32'd1);
                check("busy_in_frame", 32'(busy), 32'd1);
                bits = {bits[30:0], miso_pin};
            end else begin
                check("oe_after_rst", 32'(miso_oe), 32'd0);
                check("busy_after_rst", 32'(busy), 32'd0);
            end
            repeat (half) @(negedge clk);
            clk_pin = 1'b0;
            if (k == chg_edge) adc_value = chg_val;
            if (k == rst_edge) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                aborted = 1'b1;
                model_frames = 0;
                check("rst_miso", 32'(miso_pin), 32'd0);
                check("rst_count", 32'(frame_count), 32'd0);
            end
        end
        repeat (half) @(negedge clk);
        cs_pin_n = 1'b1;
        repeat (4) @(negedge clk);
        check("oe_after_cs", 32'(miso_oe), 32'd0);
        check("miso_after_cs", 32'(miso_pin), 32'd0);
        check("busy_after_cs", 32'(busy), 32'd0);
        if (!aborted && nclk >= 15) model_frames = model_frames + 1;
        check("done_pulses", 32'(done_cnt - d0),
              32'(!aborted && nclk >= 15));
        check("short_pulses", 32'(short_cnt - s0),
              32'(!aborted && nclk < 15));
        check("frame_count", 32'(frame_count), 32'(model_frames[15:0]));
        check("frame_count_w", 32'(frame_count2), 32'(model_frames[1:0]));
        repeat (half) @(negedge clk);
    endtask

    logic [31:0] bits;
    logic [11:0] rv;
    int          halves[3] = '{4, 25, 100};

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_miso", 32'(miso_pin), 32'd0);
        check("reset_oe", 32'(miso_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(frame_done), 32'd0);
        check("reset_short", 32'(short_frame), 32'd0);
        check("reset_count", 32'(frame_count), 32'd0);
        repeat (4) @(negedge clk);

        frame(12'hA5C, 15, 25, 0, 12'h000, 0, bits);
        check("t1_word", bits[11:0], 32'h0000_0A5C);
        check("t1_count", 32'(frame_count), 32'd1);

        frame(12'h801, 26, 6, 0, 12'h000, 0, bits);
        check("t2_bits", bits[25:0],
              32'(26'b000_1000_0000_0001_000_0000_0001));

        frame(12'h5A5, 6, 6, 0, 12'h000, 0, bits);
        check("t3_count", 32'(frame_count), 32'd2);

        frame(12'h123, 15, 5, 5, 12'hFFF, 0, bits);
        check("t4_word", bits[11:0], 32'h0000_0123);

        frame(12'hFFF, 15, 6, 0, 12'h000, 8, bits);
        check("t5_count", 32'(frame_count), 32'd0);

        repeat (6) begin
            repeat (5) @(negedge clk);
            clk_pin = ~clk_pin;
        end
        check("cs_high_clk_busy", 32'(busy), 32'd0);

        frame(12'hFFF, 28, 4, 0, 12'h000, 0, bits);
        check("ffff_zero_tail", bits[1:0], 32'd0);
        frame(12'h000, 15, 4, 0, 12'h000, 0, bits);
        check("zero_word", bits[11:0], 32'd0);

        for (int i = 0; i < 24; i++) begin
            rv = 12'($urandom);
            frame(rv, 15, halves[i % 3], 0, 12'h000, 0, bits);
            check("rand_word", bits[11:0], 32'(rv));
        end
        check("final_count", 32'(frame_count), 32'd26);
        check("final_count_w", 32'(frame_count2), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
